counter_btn_ctrl: RTL and testbench

Input conditioner upstream of the 7-segment counter. It takes two raw, asynchronous, bouncing push-button inputs and converts each into a clean toggled control level. The `pause` and `reverse` levels drive the counter's control ports directly. It also emits a one-cycle press event per button for status logic.

---
 rtl/counter_btn_ctrl.sv | 125 ++++++++++++
 tb/tb_counter_btn_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/counter_btn_ctrl.sv
// Two-button input conditioner: each raw button is synchronized, debounced and
// turned into a toggled level plus a one-cycle press event.
module counter_btn_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_pause,
   input  logic       btn_reverse,
   output logic       pause,
   output logic       reverse,
   output logic [1:0] press_evt
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic [1:0] btn_raw;
   logic [1:0] level_w;
   logic [1:0] evt_w;

   assign btn_raw = {btn_reverse, btn_pause};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         logic          sync1_reg;
         logic          sync2_reg;
         state_t        state_reg;
         state_t        state_next;
         logic [CW-1:0] cnt_reg;
         logic [CW-1:0] cnt_next;
         logic          level_reg;
         logic          evt_reg;
         logic          accept;

         // State register; level and event flops are fed by the accept decode
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               state_reg <= IDLE;
               cnt_reg   <= CNT_ZERO;
               level_reg <= 1'b0;
               evt_reg   <= 1'b0;
            end else begin
               sync1_reg <= btn_raw[gi];
               sync2_reg <= sync1_reg;
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
               level_reg <= level_reg ^ accept;
               evt_reg   <= accept;
            end
         end

         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            case (state_reg)
               IDLE: begin
                  if (sync2_reg) begin
                     state_next = PRESS_WAIT;
                     cnt_next   = CNT_ONE;
                  end else begin
                     cnt_next   = CNT_ZERO;
                  end
               end
               PRESS_WAIT: begin
                  if (!sync2_reg) begin
                     state_next = IDLE;
                     cnt_next   = CNT_ZERO;
                  end else if (cnt_reg == CNT_LAST) begin
                     state_next = HELD;
                     cnt_next   = CNT_ZERO;
                  end else begin
                     cnt_next   = cnt_reg + CNT_ONE;
                  end
               end
               HELD: begin
                  if (!sync2_reg) begin
                     state_next = RELEASE_WAIT;
                     cnt_next   = CNT_ONE;
                  end
               end
               RELEASE_WAIT: begin
                  if (sync2_reg) begin
                     state_next = HELD;
                     cnt_next   = CNT_ZERO;
                  end else if (cnt_reg == CNT_LAST) begin
                     state_next = IDLE;
                     cnt_next   = CNT_ZERO;
                  end else begin
                     cnt_next   = cnt_reg + CNT_ONE;
                  end
               end
               default: begin
                  state_next = IDLE;
                  cnt_next   = CNT_ZERO;
               end
            endcase
         end

         // A press is accepted on the last qualifying sample of PRESS_WAIT
         always_comb begin
            accept = (state_reg == PRESS_WAIT) && sync2_reg && (cnt_reg == CNT_LAST);
         end

         assign level_w[gi] = level_reg;
         assign evt_w[gi]   = evt_reg;
      end
   endgenerate

   assign pause     = level_w[0];
   assign reverse   = level_w[1];
   assign press_evt = evt_w;

endmodule

// File: tb/tb_counter_btn_ctrl.sv
// Directed bench for counter_btn_ctrl (N=4): expected press events are queued by
// the stimulus and checked by an independent monitor on every press_evt pulse.
module tb_counter_btn_ctrl;

   logic       clock;
   logic       reset;
   logic       btn_pause;
   logic       btn_reverse;
   logic       pause;
   logic       reverse;
   logic [1:0] press_evt;

   int total = 0;
   int bad   = 0;
   int edge_cnt = 0;

   typedef struct {
      int         at_edge;
      logic [1:0] evt;
      logic       p;
      logic       r;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   counter_btn_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .btn_pause   (btn_pause),
      .btn_reverse (btn_reverse),
      .pause       (pause),
      .reverse     (reverse),
      .press_evt   (press_evt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic push(input int at, input logic [1:0] evt, input logic p, input logic r);
      exp_t e;
      e.at_edge = at;
      e.evt     = evt;
      e.p       = p;
      e.r       = r;
      sb_q.push_back(e);
   endtask

   // Monitor: every observed press event must match the head of the scoreboard
   always @(negedge clock) begin
      if (reset && press_evt != 2'b00) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_evt", int'(press_evt), 0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("evt_edge", edge_cnt, mon_e.at_edge);
            chk("evt_bits", int'(press_evt), int'(mon_e.evt));
            chk("evt_pause", int'(pause), int'(mon_e.p));
            chk("evt_reverse", int'(reverse), int'(mon_e.r));
            $display("event at edge %0d evt=%b pause=%b reverse=%b", edge_cnt, press_evt, pause, reverse);
         end
      end
   end

   logic [6:0] bpat;

   initial begin
      reset       = 1'b0;
      btn_pause   = 1'b0;
      btn_reverse = 1'b0;
      bpat        = 7'b1011011;

      // reset with buttons toggling
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         btn_pause   = ~btn_pause;
         btn_reverse = ~btn_reverse;
         chk("reset_pause", int'(pause), 0);
         chk("reset_reverse", int'(reverse), 0);
         chk("reset_evt", int'(press_evt), 0);
      end
      @(negedge clock);
      btn_pause   = 1'b0;
      btn_reverse = 1'b0;
      reset       = 1'b1;
      tick(4);

      // clean press held for 10 edges
      btn_pause = 1'b1;
      push(edge_cnt + 6, 2'b01, 1'b1, 1'b0);
      tick(10);
      btn_pause = 1'b0;
      tick(8);
      chk("clean_level", int'(pause), 1);

      // bounce on reverse: 1,1,0,1,1,0,1
      for (int i = 0; i < 7; i++) begin
         btn_reverse = bpat[i];
         tick(1);
      end
      btn_reverse = 1'b0;
      tick(8);
      chk("bounce_level", int'(reverse), 0);

      // two clean press/release cycles at minimum spacing
      for (int i = 0; i < 2; i++) begin
         btn_pause = 1'b1;
         push(edge_cnt + 6, 2'b01, (i == 0) ? 1'b0 : 1'b1, 1'b0);
         tick(5);
         btn_pause = 1'b0;
         tick(5);
      end
      tick(4);
      chk("repeat_level", int'(pause), 1);

      // 2-edge low dip while held must not retoggle
      btn_pause = 1'b1;
      push(edge_cnt + 6, 2'b01, 1'b0, 1'b0);
      tick(6);
      btn_pause = 1'b0;
      tick(2);
      btn_pause = 1'b1;
      tick(6);
      btn_pause = 1'b0;
      tick(8);
      chk("dip_level", int'(pause), 0);

      // simultaneous presses
      btn_pause   = 1'b1;
      btn_reverse = 1'b1;
      push(edge_cnt + 6, 2'b11, 1'b1, 1'b1);
      tick(6);
      btn_pause   = 1'b0;
      btn_reverse = 1'b0;
      tick(8);
      chk("simul_pause", int'(pause), 1);
      chk("simul_reverse", int'(reverse), 1);

      // reset in the middle of a pause debounce, button kept high
      btn_pause = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);
      chk("midrst_pause", int'(pause), 0);
      chk("midrst_reverse", int'(reverse), 0);
      chk("midrst_evt", int'(press_evt), 0);
      tick(1);
      reset = 1'b1;
      push(edge_cnt + 6, 2'b01, 1'b1, 1'b0);
      tick(10);
      btn_pause = 1'b0;
      tick(8);
      chk("midrst_level_p", int'(pause), 1);
      chk("midrst_level_r", int'(reverse), 0);

      chk("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
